// File: rtl/csa_fold_acc.sv
// csa_fold_acc: folded carry-save multi-operand accumulator.
// One operand per cycle is folded into a redundant sum/carry pair through a
// single 3:2 level; the operand flagged last triggers one carry-propagate add
// and the result is held until the consumer takes it.
module csa_fold_acc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_cnt_sat
);

    typedef enum logic [1:0] {ACC, ADD, OUT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] s, c, r;
    logic [WIDTH-1:0] s_nxt, c_nxt, maj;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             accept;

    // Handshake flags depend on state alone, so no path from in_valid/out_ready.
    assign in_ready    = (state == ACC);
    assign out_valid   = (state == OUT);
    assign accept      = in_valid && (state == ACC);
    assign out_sum     = r;
    assign out_count   = cnt;
    assign out_cnt_sat = sat;

    // One 3:2 level: bitwise sum, majority shifted up one place, top carry dropped.
    always_comb begin
        s_nxt = s ^ c ^ in_data;
        maj   = (s & c) | (s & in_data) | (c & in_data);
        c_nxt = {maj[WIDTH-2:0], 1'b0};
    end

    // Control FSM together with the accumulator, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            s     <= '0;
            c     <= '0;
            r     <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        s <= s_nxt;
                        c <= c_nxt;
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                        // Flag as soon as the count lands on the ceiling.
                        if (cnt >= CNT_MAX - 1'b1)
                            sat <= 1'b1;
                        if (in_last)
                            state <= ADD;
                    end
                end
                ADD: begin
                    r     <= s + c;
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        s     <= '0;
                        c     <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_fold_acc.sv
// Directed and randomised checks for csa_fold_acc (WIDTH=32, CNT_W=4).
module tb_csa_fold_acc;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_cnt_sat;

    int n_cmp = 0;
    int n_bad = 0;

    csa_fold_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_count   (out_count),
        .out_cnt_sat (out_cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for exactly one edge (caller guarantees ACC).
    task automatic push(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bounded wait for out_valid; expiry counts as a failed comparison.
    task automatic wait_out();
        int i;
        for (i = 0; i < 100 && out_valid !== 1'b1; i++)
            tick();
        if (out_valid !== 1'b1)
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] sum,
                                input int cnt, input logic sat);
        chk({tag, "_sum"}, out_sum, sum);
        chk({tag, "_cnt"}, 32'(out_count), 32'(cnt));
        chk({tag, "_sat"}, 32'(out_cnt_sat), 32'(sat));
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_sum;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #13;
        rst_n = 1'b1;
        tick();

        // Reset / idle
        for (int i = 0; i < 10; i++) begin
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_out_sum", out_sum, 32'd0);
            chk("idle_out_count", 32'(out_count), 32'd0);
            tick();
        end

        // Basic group with exact latency and one-cycle pulse
        out_ready = 1'b1;
        push(32'd5, 1'b0);
        push(32'd7, 1'b0);
        push(32'd9, 1'b1);
        chk("basic_add_no_valid", 32'(out_valid), 32'd0);
        chk("basic_add_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("basic_valid_t1", 32'(out_valid), 32'd1);
        check_result("basic", 32'd21, 3, 1'b0);
        tick();
        chk("basic_pulse_end", 32'(out_valid), 32'd0);
        chk("basic_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Wrap-around and single-operand group
        push(32'hFFFF_FFFF, 1'b0);
        push(32'h0000_0001, 1'b0);
        push(32'h8000_0000, 1'b0);
        push(32'h8000_0000, 1'b1);
        wait_out();
        check_result("wrap", 32'h0, 4, 1'b0);
        take();
        push(32'hDEAD_BEEF, 1'b1);
        wait_out();
        check_result("single", 32'hDEAD_BEEF, 1, 1'b0);
        take();

        // Gapped input plus backpressure, with junk offered while stalled
        for (int i = 1; i <= 10; i++) begin
            push(32'(i), i == 10);
            if (i != 10) tick();
        end
        wait_out();
        in_valid = 1'b1;
        in_data  = 32'd100;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            check_result("stall", 32'd55, 10, 1'b0);
            tick();
        end
        take();
        in_valid = 1'b0;
        push(32'd2, 1'b1);
        wait_out();
        check_result("after_stall", 32'd2, 1, 1'b0);
        take();

        // Counter saturation at 15
        for (int i = 0; i < 20; i++)
            push(32'd3, i == 19);
        wait_out();
        check_result("sat", 32'd60, 15, 1'b1);
        take();
        push(32'd1, 1'b0);
        push(32'd1, 1'b1);
        wait_out();
        check_result("post_sat", 32'd2, 2, 1'b0);
        take();

        // Exactly 15 operands reaches the ceiling
        for (int i = 0; i < 15; i++)
            push(32'd1, i == 14);
        wait_out();
        check_result("sat_edge", 32'd15, 15, 1'b1);
        take();

        // Reset mid-group in ACC
        push(32'd4, 1'b0);
        push(32'd4, 1'b0);
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            chk("rst_acc_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        // Reset while holding a result in OUT
        push(32'd7, 1'b1);
        wait_out();
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_no_valid", 32'(out_valid), 32'd0);
            chk("rst_out_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        push(32'd6, 1'b1);
        wait_out();
        check_result("after_rst", 32'd6, 1, 1'b0);
        take();

        // Random regression against a plain-addition model
        for (int g = 0; g < 1000; g++) begin
            exp_sum = '0;
            n = $urandom_range(1, 18);
            for (int k = 0; k < n; k++) begin
                logic [31:0] d;
                d = $urandom;
                exp_sum = exp_sum + d;
                push(d, k == n - 1);
                if (k != n - 1 && $urandom_range(0, 3) == 0) tick();
            end
            wait_out();
            repeat ($urandom_range(0, 2)) tick();
            check_result("rand", exp_sum, (n > 15) ? 15 : n, n >= 15);
            take();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
